// File: rtl/imm_const_encoder_pkg.sv
// Shared constants and types for the constant-to-instruction encoder.
// Holds the MIPS opcodes, the encoding-class enum and the FSM state enum.
package imm_const_encoder_pkg;

    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        SEXT,
        ZEXT,
        UPPER,
        PAIR
    } enc_class_t;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        PAIR_HI
    } state_t;

    // I-type layout: opcode | rs | rt | imm16
    function automatic logic [31:0] i_type(input logic [5:0]  opc,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imm_class_sel.sv
// Pure combinational classifier: picks the shortest encoding class for a constant.
// SIGNED_FIRST selects whether the ADDIU or the ORI form wins when both fit.
module imm_class_sel
    import imm_const_encoder_pkg::*;
#(
    parameter bit SIGNED_FIRST = 1'b1
)(
    input  logic [31:0] value,
    output enc_class_t  cls
);

    logic fits_sext;
    logic fits_zext;
    logic fits_upper;

    assign fits_sext  = (&value[31:15]) | ~(|value[31:15]);
    assign fits_zext  = ~(|value[31:16]);
    assign fits_upper = ~(|value[15:0]);

    // NOTE: cls gets a default before any branch so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        cls = PAIR;
        if (SIGNED_FIRST) begin
            if (fits_sext)       cls = SEXT;
            else if (fits_zext)  cls = ZEXT;
            else if (fits_upper) cls = UPPER;
        end else begin
            if (fits_zext)       cls = ZEXT;
            else if (fits_sext)  cls = SEXT;
            else if (fits_upper) cls = UPPER;
        end
    end

endmodule

// File: rtl/imm_const_encoder.sv
// Turns a 32-bit constant and a destination register into ADDIU/ORI/LUI/LUI+ORI words
// on a valid/ready stream. Optional counters: IMM_CONST_ENCODER_STATS_EN.
module imm_const_encoder
    import imm_const_encoder_pkg::*;
#(
    parameter bit SIGNED_FIRST = 1'b1
`ifdef IMM_CONST_ENCODER_STATS_EN
   ,parameter int STAT_W = 16
`endif
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
`ifdef IMM_CONST_ENCODER_STATS_EN
   ,output logic [STAT_W-1:0] stat_consts,
    output logic [STAT_W-1:0] stat_pairs
`endif
);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [4:0]  pend_rt_q, pend_rt_d;
    logic [15:0] pend_lo_q, pend_lo_d;

    enc_class_t  cls;
    logic [31:0] first_instr;
    logic        first_last;
    logic        req_fire;
    logic        out_fire;

    imm_class_sel #(
        .SIGNED_FIRST(SIGNED_FIRST)
    ) u_class_sel (
        .value(in_value),
        .cls  (cls)
    );

    assign in_ready  = !valid_q || (out_ready && last_q);
    assign req_fire  = in_valid && in_ready;
    assign out_fire  = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_last  = last_q;

    always_comb begin
        first_instr = i_type(OPC_ADDIU, REG_ZERO, in_rt, in_value[15:0]);
        first_last  = 1'b1;
        case (cls)
            ZEXT:    first_instr = i_type(OPC_ORI, REG_ZERO, in_rt, in_value[15:0]);
            UPPER:   first_instr = i_type(OPC_LUI, REG_ZERO, in_rt, in_value[31:16]);
            PAIR: begin
                first_instr = i_type(OPC_LUI, REG_ZERO, in_rt, in_value[31:16]);
                first_last  = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        last_d    = last_q;
        pend_rt_d = pend_rt_q;
        pend_lo_d = pend_lo_q;

        // A retiring SINGLE word with no follow-on request empties the output.
        if (state_q == SINGLE && out_fire) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (state_q == PAIR_HI && out_fire) begin
            state_d = SINGLE;
            instr_d = i_type(OPC_ORI, pend_rt_q, pend_rt_q, pend_lo_q);
            last_d  = 1'b1;
        end else if (req_fire) begin
            state_d   = first_last ? SINGLE : PAIR_HI;
            instr_d   = first_instr;
            valid_d   = 1'b1;
            last_d    = first_last;
            pend_rt_d = in_rt;
            pend_lo_d = in_value[15:0];
        end
    end

    // NOTE: state registers are updated only with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= 32'h0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            pend_rt_q <= 5'd0;
            pend_lo_q <= 16'h0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            pend_rt_q <= pend_rt_d;
            pend_lo_q <= pend_lo_d;
        end
    end

`ifdef IMM_CONST_ENCODER_STATS_EN
    // Saturating counters: they stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_consts <= '0;
            stat_pairs  <= '0;
        end else if (req_fire) begin
            if (stat_consts != '1)
                stat_consts <= stat_consts + 1'b1;
            if (cls == PAIR && stat_pairs != '1)
                stat_pairs <= stat_pairs + 1'b1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_imm_const_encoder.sv
// Directed bench for imm_const_encoder: a scoreboard of expected words is filled when
// a request is driven and drained by a monitor as the DUT retires words.
module tb_imm_const_encoder;

    localparam bit SF = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    imm_const_encoder #(
        .SIGNED_FIRST(SF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_rt    (in_rt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Reference model written from the encoding rules, using range tests on the value.
    task automatic push_exp(input logic [31:0] v, input logic [4:0] rt);
        bit sext, zext, upper;
        exp_t e;
        sext  = ($signed(v) >= -32'sd32768) && ($signed(v) <= 32'sd32767);
        zext  = (v < 32'h0001_0000);
        upper = ((v % 32'h0001_0000) == 0);
        if ((SF && sext) || (!SF && !zext && sext)) begin
            e.instr = (32'h09 << 26) | (32'(rt) << 16) | (v & 32'hFFFF);
            e.last  = 1'b1; sb.push_back(e);
        end else if (zext) begin
            e.instr = (32'h0D << 26) | (32'(rt) << 16) | (v & 32'hFFFF);
            e.last  = 1'b1; sb.push_back(e);
        end else if (upper) begin
            e.instr = (32'h0F << 26) | (32'(rt) << 16) | (v >> 16);
            e.last  = 1'b1; sb.push_back(e);
        end else begin
            e.instr = (32'h0F << 26) | (32'(rt) << 16) | (v >> 16);
            e.last  = 1'b0; sb.push_back(e);
            e.instr = (32'h0D << 26) | (32'(rt) << 21) | (32'(rt) << 16) | (v & 32'hFFFF);
            e.last  = 1'b1; sb.push_back(e);
        end
    endtask

    // Monitor: a word retires when out_valid && out_ready are seen mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word", out_instr, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                check("word", out_instr, e.instr);
                check("word_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [4:0] rt, output int waited);
        push_exp(v, rt);
        in_valid = 1'b1;
        in_value = v;
        in_rt    = rt;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 20) begin
                check("accept_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [31:0] pat_v  [8] = '{32'h0000_0000, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000,
                                32'h0001_0000, 32'h8000_0000, 32'h0001_0001, 32'hFFFF_0001};
    logic [4:0]  pat_rt [8] = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd31, 5'd4, 5'd5, 5'd6};

    initial begin
        int   w;
        logic [31:0] held;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 32'h0;
        in_rt     = 5'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // all-ones constant: single ADDIU, valid one cycle after acceptance
        send(32'hFFFF_FFFF, 5'd8, w);
        check("addiu_latency_valid", {31'd0, out_valid}, 32'd1);
        check("addiu_word", out_instr, 32'h2408_FFFF);
        check("addiu_last", {31'd0, out_last}, 32'd1);
        drain();

        send(32'h0000_8000, 5'd9, w);
        check("ori_word", out_instr, 32'h3409_8000);
        drain();

        send(32'h1234_0000, 5'd10, w);
        check("lui_word", out_instr, 32'h3C0A_1234);
        drain();

        // pair with consumer stalled for three cycles
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd8, w);
        check("pair_hi_word", out_instr, 32'h3C08_1234);
        check("pair_hi_last", {31'd0, out_last}, 32'd0);
        held = out_instr;
        repeat (3) begin
            @(negedge clk);
            check("stall_instr_stable", out_instr, held);
            check("stall_last_low", {31'd0, out_last}, 32'd0);
            check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("pair_hi_retire_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("pair_lo_word", out_instr, 32'h3508_5678);
        check("pair_lo_last", {31'd0, out_last}, 32'd1);
        drain();

        // back-to-back: second request accepted on the first word's retire cycle
        send(32'h0000_0005, 5'd3, w);
        send(32'h1234_5678, 5'd8, w);
        check("b2b_no_wait", 32'(w), 32'd0);
        check("b2b_no_bubble", {31'd0, out_valid}, 32'd1);
        check("b2b_second_word", out_instr, 32'h3C08_1234);
        drain();

        for (int i = 0; i < 8; i++) begin
            send(pat_v[i], pat_rt[i], w);
            check("pattern_valid", {31'd0, out_valid}, 32'd1);
            drain();
        end

        // reset while the upper half of a pair is pending
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd8, w);
        check("pre_rst_last", {31'd0, out_last}, 32'd0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_instr", out_instr, 32'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
